fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction fetch stage for the RISC-V core. It holds the PC, requests instructions from instruction memory over a req/ack handshake, and latches the returned word. That word drives the immediate extender and the decoder. Once the core retires the instruction, the block computes the next PC from the decoder's PCSrc, the extended immediate and the ALU result.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0013, value driven on instr while no valid instruction is held (addi x0,x0,0).

Ports:
clk  input  1  core clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
imem_req  output  1  fetch request to instruction memory
imem_addr  output  32  fetch address; equals pc
imem_ack  input  1  memory returns imem_rdata this cycle
imem_rdata  input  32  fetched instruction word
instr  output  32  latched instruction; feeds immediate extender and decoder
instr_valid  output  1  instr holds a fetched, not-yet-retired instruction
instr_ready  input  1  core retires the current instruction this cycle
PCSrc  input  2  next-PC select: 00 PC+4, 01 PC+ImmExt (branch/JAL), 10 ALU result & ~1 (JALR), 11 reserved (treated as 00)
ImmExt  input  32  sign-extended immediate from extender
alu_result  input  32  JALR target from ALU
pc  output  32  address of the current instruction
pc_plus4  output  32  pc + 4 (mod 2^32), for JAL/JALR link writeback
halted  output  1  sticky; set on an instruction-address-misaligned target

Behaviour:
- Reset (synchronous, active-high, wins over all other inputs):
  - pc=RESET_PC, instr=NOP_INSTR, instr_valid=0, imem_req=0, halted=0, state=IDLE.
- States: IDLE, FETCH, HOLD, HALT.
- IDLE:
  - Entered only from reset.
  - First cycle after reset deasserts: go to FETCH with imem_req=1 registered, visible on the next cycle.
- FETCH:
  - imem_req=1; imem_addr=pc, stable until ack.
  - On imem_ack: instr<=imem_rdata, instr_valid<=1, imem_req<=0, go to HOLD.
  - Minimum latency: ack in the first FETCH cycle gives instr_valid=1 on the following cycle.
  - Arbitrary ack wait allowed; no timeout.
- HOLD:
  - instr and instr_valid stay stable while instr_ready=0.
  - PCSrc, ImmExt and alu_result are sampled only in the cycle where instr_ready=1.
  - On instr_ready=1:
    - compute next_pc;
    - if next_pc[1:0]!=00 after JALR masking: go to HALT;
    - else pc<=next_pc, instr_valid<=0, instr<=NOP_INSTR, imem_req<=1, go to FETCH.
- HALT:
  - halted=1, imem_req=0, instr_valid=0.
  - pc keeps the address of the faulting instruction.
  - Left only by reset.
- Arithmetic: all adds are 32-bit, modulo 2^32 (wrap silently; no carry out).
  - PC+4 from 32'hFFFF_FFFC gives 0.
  - JALR target = alu_result & 32'hFFFF_FFFE, so bit0 never causes a halt.
- pc_plus4 is combinational from pc.
- imem_ack outside FETCH is ignored, including a late ack after reset.
- instr_ready outside HOLD is ignored.
- Reset during FETCH drops imem_req on the next edge; an outstanding response is discarded.

Test Plan:
- Reset with RESET_PC=32'h100 → pc=32'h100, instr=32'h00000013, instr_valid=0, imem_req=0; one cycle after deassert imem_req=1, imem_addr=32'h100.
- Ack on first FETCH cycle with rdata=32'h00500093 → next cycle instr=32'h00500093, instr_valid=1, imem_req=0; instr_ready=1, PCSrc=00 → pc=32'h104, imem_req=1.
- Branch: pc=32'h200, PCSrc=01, ImmExt=32'hFFFF_FFF0, instr_ready=1 → pc=32'h1F0. Also PC+4 at 32'hFFFF_FFFC → pc=0.
- JALR: PCSrc=10, alu_result=32'h0000_0305 → pc=32'h304. alu_result=32'h0000_0306 → halted=1, pc unchanged, imem_req stays 0 for 10 cycles.
- Ack delayed 5 cycles with instr_ready held 1 throughout → imem_addr stable and pc unchanged until ack; no spurious advance.
- Reset asserted while imem_req=1, ack arrives the cycle after → ignored, instr=NOP_INSTR, instr_valid=0; refetch from RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over a req/ack handshake
// and computes the next PC once the core retires the held instruction.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] ImmExt,
  input  logic [31:0] alu_result,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        halted
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_HOLD,
    S_HALT
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_target;
  logic        w_misalign;
  logic        w_retire;
  logic        w_fill;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_retire   = (r_state == S_HOLD) && instr_ready;
  assign w_fill     = (r_state == S_FETCH) && imem_ack;

  // JALR clears bit0 so only bit1 can flag a misaligned target
  always_comb begin
    w_target = w_pc_plus4;
    case (PCSrc)
      2'b01:   w_target = r_pc + ImmExt;
      2'b10:   w_target = alu_result & 32'hFFFF_FFFE;
      default: w_target = w_pc_plus4;
    endcase
  end

  assign w_misalign = (w_target[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  w_state_nxt = S_FETCH;
      S_FETCH: if (imem_ack) w_state_nxt = S_HOLD;
      S_HOLD: begin
        if (instr_ready) begin
          w_state_nxt = w_misalign ? S_HALT : S_FETCH;
        end
      end
      S_HALT:  w_state_nxt = S_HALT;
    endcase
  end

  always_comb begin
    imem_req    = (r_state == S_FETCH);
    instr_valid = (r_state == S_HOLD);
    halted      = (r_state == S_HALT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc    <= RESET_PC;
      r_instr <= NOP_INSTR;
    end else if (w_fill) begin
      r_instr <= imem_rdata;
    end else if (w_retire) begin
      r_instr <= NOP_INSTR;
      if (!w_misalign) r_pc <= w_target;
    end
  end

  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign pc_plus4  = w_pc_plus4;
  assign instr     = r_instr;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit, checked cycle by cycle against a
// transaction-level model of the fetch/retire behaviour.
module tb_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [1:0]  PCSrc;
  logic [31:0] ImmExt;
  logic [31:0] alu_result;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        halted;

  int n_chk = 0;
  int n_err = 0;

  fetch_unit #(.RESET_PC(RPC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .PCSrc(PCSrc),
    .ImmExt(ImmExt), .alu_result(alu_result),
    .pc(pc), .pc_plus4(pc_plus4), .halted(halted)
  );

  always #5 clk = ~clk;

  // model: "phase" is a notion of where the fetch transaction stands
  bit          m_boot;
  bit          m_wait;
  bit          m_have;
  bit          m_halt;
  logic [31:0] m_pc;
  logic [31:0] m_instr;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_edge();
    longint t;
    if (reset) begin
      m_boot = 1; m_wait = 0; m_have = 0; m_halt = 0;
      m_pc = RPC; m_instr = NOP;
    end else if (m_boot) begin
      m_boot = 0; m_wait = 1;
    end else if (m_halt) begin
      // only reset leaves
    end else if (m_wait) begin
      if (imem_ack) begin
        m_instr = imem_rdata; m_wait = 0; m_have = 1;
      end
    end else if (m_have && instr_ready) begin
      if (PCSrc == 2'd1)      t = longint'(m_pc) + longint'(ImmExt);
      else if (PCSrc == 2'd2) t = longint'(alu_result) / 2 * 2;
      else                    t = longint'(m_pc) + 4;
      t = t % 64'h1_0000_0000;
      m_have = 0; m_instr = NOP;
      if (t % 4 != 0) m_halt = 1;
      else begin
        m_pc = t[31:0]; m_wait = 1;
      end
    end
  endfunction

  task automatic check_all();
    chk("pc", pc, m_pc);
    chk("addr", imem_addr, m_pc);
    chk("pc4", pc_plus4, m_pc + 32'd4);
    chk("instr", instr, m_instr);
    chk("valid", {31'd0, instr_valid}, {31'd0, m_have});
    chk("req", {31'd0, imem_req}, {31'd0, m_wait});
    chk("halted", {31'd0, halted}, {31'd0, m_halt});
  endtask

  task automatic cyc(input bit rst, input bit ack, input logic [31:0] rd,
                     input bit rdy, input logic [1:0] src,
                     input logic [31:0] imm, input logic [31:0] alu);
    reset = rst; imem_ack = ack; imem_rdata = rd;
    instr_ready = rdy; PCSrc = src; ImmExt = imm; alu_result = alu;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle_cyc();
    cyc(0, 0, $urandom, 0, 2'($urandom), $urandom, $urandom);
  endtask

  // retire the currently held instruction, then land in FETCH
  task automatic fetch_retire(input logic [31:0] w, input logic [1:0] src,
                              input logic [31:0] imm, input logic [31:0] alu);
    cyc(0, 1, w, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, src, imm, alu);
  endtask

  initial begin
    reset = 1; imem_ack = 0; imem_rdata = 0; instr_ready = 0;
    PCSrc = 0; ImmExt = 0; alu_result = 0;
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 32'hDEAD_BEEF, 1, 0, 0, 0);
    chk("rst_pc", pc, 32'h100);
    chk("rst_instr", instr, 32'h13);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("boot_req", {31'd0, imem_req}, 32'd1);
    chk("boot_addr", imem_addr, 32'h100);

    cyc(0, 1, 32'h0050_0093, 0, 0, 0, 0);
    chk("fill_instr", instr, 32'h0050_0093);
    chk("fill_valid", {31'd0, instr_valid}, 32'd1);
    cyc(0, 0, 0, 1, 2'b00, 0, 0);
    chk("seq_pc", pc, 32'h104);
    chk("seq_req", {31'd0, imem_req}, 32'd1);

    fetch_retire(32'h0000_006F, 2'b01, 32'h0000_00FC, 0);
    chk("jal_pc", pc, 32'h200);
    fetch_retire(32'hFE00_08E3, 2'b01, 32'hFFFF_FFF0, 0);
    chk("br_pc", pc, 32'h1F0);
    fetch_retire(32'h0000_0067, 2'b10, 0, 32'hFFFF_FFFD);
    chk("top_pc", pc, 32'hFFFF_FFFC);
    fetch_retire(32'h0000_0013, 2'b11, 32'h40, 32'h80);
    chk("wrap_pc", pc, 32'h0);
    fetch_retire(32'h0000_0067, 2'b10, 0, 32'h0000_0305);
    chk("jalr_pc", pc, 32'h304);
    fetch_retire(32'h0000_0067, 2'b10, 0, 32'h0000_0306);
    chk("halt", {31'd0, halted}, 32'd1);
    chk("halt_pc", pc, 32'h304);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 1, $urandom, 1, 2'($urandom), $urandom, $urandom);
      chk("halt_req", {31'd0, imem_req}, 32'd0);
    end

    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, $urandom, 1, 2'b01, 32'h40, 0);
      chk("wait_addr", imem_addr, 32'h100);
    end
    cyc(0, 1, 32'h0010_0113, 1, 2'b01, 32'h40, 0);
    chk("late_instr", instr, 32'h0010_0113);
    chk("late_pc", pc, 32'h100);

    cyc(0, 0, 0, 1, 0, 0, 0);
    chk("pre_rst_req", {31'd0, imem_req}, 32'd1);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'h1234_5678, 1, 0, 0, 0);
    chk("drop_instr", instr, 32'h13);
    chk("drop_valid", {31'd0, instr_valid}, 32'd0);
    chk("refetch", imem_addr, 32'h100);

    for (int i = 0; i < 4000; i++) begin
      bit          r;
      logic [31:0] imm;
      logic [31:0] alu;
      r   = ($urandom_range(0, 99) == 0) || (m_halt && $urandom_range(0, 7) == 0);
      imm = $urandom & 32'hFFFF_FFFC;
      alu = $urandom & 32'hFFFF_FFFD;
      if ($urandom_range(0, 15) == 0) imm = $urandom;
      if ($urandom_range(0, 15) == 0) alu = $urandom;
      cyc(r, $urandom_range(0, 2) == 0, $urandom,
          $urandom_range(0, 1) == 1, 2'($urandom), imm, alu);
    end
    idle_cyc();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
